// File: rtl/gddr6_rd_scheduler.sv
// GDDR6 read-command scheduler: two-port round-robin intake, one pending request,
// per-bank open-row tracking and PREpb/ACT/RD issue under tRP, tRCD and tCCD_S/L.
module gddr6_rd_scheduler #(
  parameter int unsigned T_RCD   = 4,
  parameter int unsigned T_RP    = 4,
  parameter int unsigned T_CCD_S = 2,
  parameter int unsigned T_CCD_L = 4
) (
  input  logic        CLK_t,
  input  logic        RESET,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_bank,
  input  logic [14:0] req0_row,
  input  logic [6:0]  req0_col,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_bank,
  input  logic [14:0] req1_row,
  input  logic [6:0]  req1_col,
  input  logic        bank_group_en,
  output logic        cmd_valid,
  output logic [4:0]  cmd_code,
  output logic [3:0]  cmd_bank,
  output logic [14:0] cmd_row,
  output logic [6:0]  cmd_col,
  output logic        cmd_src
);

  localparam int unsigned TW = 8;
  localparam int unsigned CcdMax = (T_CCD_L > T_CCD_S) ? T_CCD_L : T_CCD_S;

  localparam logic [TW-1:0] RpLoad    = TW'(T_RP - 1);
  localparam logic [TW-1:0] RcdLoad   = TW'(T_RCD - 1);
  localparam logic [TW-1:0] CcdLoad   = TW'(CcdMax - 1);
  // The tCCD counter always starts from the larger spacing; a shorter spacing is
  // satisfied once the counter has fallen far enough.
  localparam logic [TW-1:0] CcdShortOk = TW'(CcdMax - T_CCD_S);
  localparam logic [TW-1:0] CcdLongOk  = TW'(CcdMax - T_CCD_L);

  localparam logic [4:0] CmdNop = 5'b00000;
  localparam logic [4:0] CmdAct = 5'b00100;
  localparam logic [4:0] CmdRd  = 5'b00101;
  localparam logic [4:0] CmdPre = 5'b10000;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDecide = 3'd1;
  localparam logic [2:0] StPre    = 3'd2;
  localparam logic [2:0] StAct    = 3'd3;
  localparam logic [2:0] StRd     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [3:0]    pend_bank_q, pend_bank_d;
  logic [14:0]   pend_row_q, pend_row_d;
  logic [6:0]    pend_col_q, pend_col_d;
  logic          pend_src_q, pend_src_d;
  logic [15:0]   open_q, open_d;
  logic [14:0]   row_q [16];
  logic [14:0]   row_d [16];
  logic [TW-1:0] timer_q [16];
  logic [TW-1:0] timer_d [16];
  logic [TW-1:0] ccd_q, ccd_d;
  logic [1:0]    rd_bg_q, rd_bg_d;

  logic       grant;
  logic       accept;
  logic       timer_zero;
  logic       row_hit;
  logic       ccd_ok;
  logic       issue;
  logic [4:0] code;

  always_comb begin
    grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    req0_ready = (state_q == StIdle) && !RESET && req0_valid && !grant;
    req1_ready = (state_q == StIdle) && !RESET && req1_valid && grant;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    timer_zero = (timer_q[pend_bank_q] == '0);
    row_hit    = open_q[pend_bank_q] && (row_q[pend_bank_q] == pend_row_q);
    if (bank_group_en && (pend_bank_q[3:2] == rd_bg_q)) begin
      ccd_ok = (ccd_q <= CcdLongOk);
    end else begin
      ccd_ok = (ccd_q <= CcdShortOk);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_bank_d = pend_bank_q;
    pend_row_d  = pend_row_q;
    pend_col_d  = pend_col_q;
    pend_src_d  = pend_src_q;
    open_d      = open_q;
    row_d       = row_q;
    rd_bg_d     = rd_bg_q;
    ccd_d       = (ccd_q != '0) ? ccd_q - TW'(1) : '0;
    for (int i = 0; i < 16; i++) begin
      timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - TW'(1) : '0;
    end
    issue = 1'b0;
    code  = CmdNop;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StDecide;
          ptr_d       = !grant;
          pend_src_d  = grant;
          pend_bank_d = grant ? req1_bank : req0_bank;
          pend_row_d  = grant ? req1_row : req0_row;
          pend_col_d  = grant ? req1_col : req0_col;
        end
      end
      StDecide: begin
        if (row_hit) begin
          state_d = StRd;
        end else if (open_q[pend_bank_q]) begin
          state_d = StPre;
        end else begin
          state_d = StAct;
        end
      end
      StPre: begin
        if (timer_zero) begin
          issue                = 1'b1;
          code                 = CmdPre;
          open_d[pend_bank_q]  = 1'b0;
          timer_d[pend_bank_q] = RpLoad;
          state_d              = StAct;
        end
      end
      StAct: begin
        if (timer_zero) begin
          issue                = 1'b1;
          code                 = CmdAct;
          open_d[pend_bank_q]  = 1'b1;
          row_d[pend_bank_q]   = pend_row_q;
          timer_d[pend_bank_q] = RcdLoad;
          state_d              = StRd;
        end
      end
      StRd: begin
        if (timer_zero && ccd_ok) begin
          issue   = 1'b1;
          code    = CmdRd;
          ccd_d   = CcdLoad;
          rd_bg_d = pend_bank_q[3:2];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_valid = issue;
    cmd_code  = code;
    cmd_bank  = issue ? pend_bank_q : '0;
    cmd_row   = issue ? pend_row_q : '0;
    cmd_col   = issue ? pend_col_q : '0;
    cmd_src   = issue ? pend_src_q : 1'b0;
  end

  always_ff @(posedge CLK_t or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      pend_bank_q <= '0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
      pend_src_q  <= 1'b0;
      open_q      <= '0;
      ccd_q       <= '0;
      rd_bg_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        row_q[i]   <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_bank_q <= pend_bank_d;
      pend_row_q  <= pend_row_d;
      pend_col_q  <= pend_col_d;
      pend_src_q  <= pend_src_d;
      open_q      <= open_d;
      ccd_q       <= ccd_d;
      rd_bg_q     <= rd_bg_d;
      for (int i = 0; i < 16; i++) begin
        row_q[i]   <= row_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

endmodule
